// File: rtl/conv_window_filter_pkg.sv
// Shared sizing, coefficient-layout and saturation helpers for the streaming
// K x K convolution filter.
package conv_pkg;

    function automatic int acc_width(input int data_w, input int coef_w, input int k);
        return data_w + coef_w + $clog2(k * k);
    endfunction

    function automatic int coef_offset(input int r, input int c, input int k, input int coef_w);
        return (r * k + c) * coef_w;
    endfunction

    function automatic int sat_max(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int data_w);
        return -(1 << (data_w - 1));
    endfunction

    function automatic bit k_is_legal(input int k);
        return (k == 3) || (k == 5) || (k == 7);
    endfunction

endpackage

// File: rtl/conv_window_filter_line_buffer.sv
// One image line of delay: a pixel written now reappears LineWidth shifts later.
module line_buffer #(
    parameter int DataBitWidth = 12,
    parameter int LineWidth    = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           shift,
    input  logic signed [DataBitWidth-1:0] pixel,
    output logic signed [DataBitWidth-1:0] delayed
);
    localparam int PtrW = (LineWidth > 1) ? $clog2(LineWidth) : 1;

    logic signed [DataBitWidth-1:0] mem [LineWidth];
    logic [PtrW-1:0] ptr;

    // Read-before-write at the same slot gives exactly LineWidth beats of delay.
    assign delayed = mem[ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (shift) begin
            ptr <= (ptr == PtrW'(LineWidth - 1)) ? '0 : ptr + PtrW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (shift) begin
            mem[ptr] <= pixel;
        end
    end

endmodule

// File: rtl/conv_window_filter.sv
// Streaming K x K signed convolution with loadable coefficients, two-stage
// multiply / reduce pipeline and valid/ready handshakes on both sides.
module conv_window_filter
    import conv_pkg::*;
#(
    parameter int DataBitWidth   = 12,
    parameter int FilterBitWidth = 8,
    parameter int FilterSize     = 5,
    parameter int LineWidth      = 64,
    parameter int OutShift       = 0
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                coef_load,
    input  logic [FilterSize*FilterSize*FilterBitWidth-1:0]     f_coeff,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic                                                sof,
    input  logic signed [DataBitWidth-1:0]                      d_in,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic signed [DataBitWidth-1:0]                      d_out
);
    localparam int K     = FilterSize;
    localparam int DW    = DataBitWidth;
    localparam int FW    = FilterBitWidth;
    localparam int PW    = DW + FW;
    localparam int ACC_W = acc_width(DW, FW, K);
    localparam int CW    = $clog2(LineWidth);
    localparam int RW    = $clog2(K);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(DW));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(DW));

    if (!k_is_legal(K) || LineWidth < K) begin : g_bad_cfg
        $error("conv_window_filter: FilterSize must be 3, 5 or 7 and LineWidth >= FilterSize");
    end

    function automatic logic signed [DW-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[DW-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[DW-1:0];
        end
        return v[DW-1:0];
    endfunction

    logic                  en;
    logic                  accept;
    logic                  win_ok;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic signed [DW-1:0]  lb_out  [K-1];
    logic signed [DW-1:0]  col_new [K];
    logic signed [FW-1:0]  coef    [K][K];

    logic signed [DW-1:0]  win_p0  [K][K];
    logic                  vld_p0;
    logic signed [PW-1:0]  prod_p1 [K][K];
    logic                  vld_p1;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] scaled;
    logic signed [DW-1:0]  d_out_p2;
    logic                  vld_p2;

    assign en        = !vld_p2 || out_ready;
    assign in_ready  = en;
    assign accept    = in_valid && en;
    assign out_valid = vld_p2;
    assign d_out     = d_out_p2;

    // A sof beat is pixel (0,0), so it can never complete a window.
    assign win_ok = accept && !sof && (row == RW'(K - 1)) && (col >= CW'(K - 1));

    for (genvar i = 0; i < K - 1; i++) begin : g_line
        logic signed [DW-1:0] feed;
        if (i == 0) begin : g_first
            assign feed = d_in;
        end else begin : g_chain
            assign feed = lb_out[i-1];
        end
        line_buffer #(
            .DataBitWidth (DW),
            .LineWidth    (LineWidth)
        ) u_line (
            .clk     (clk),
            .rst     (rst),
            .shift   (accept),
            .pixel   (feed),
            .delayed (lb_out[i])
        );
    end

    // Row K-1 is the current line; row 0 is the oldest line in the chain.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            col_new[r] = d_in;
        end
        for (int r = 0; r < K - 1; r++) begin
            col_new[r] = lb_out[K-2-r];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (sof) begin
                row <= '0;
                col <= CW'(1);
            end else if (col == CW'(LineWidth - 1)) begin
                col <= '0;
                if (row != RW'(K - 1)) begin
                    row <= row + RW'(1);
                end
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    coef[r][c] <= '0;
                end
            end
        end else if (coef_load) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    coef[r][c] <= f_coeff[coef_offset(r, c, K, FW) +: FW];
                end
            end
        end
    end

    // Stage 0: window shift, one column per accepted beat
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_p0[r][c] <= win_p0[r][c+1];
                end
                win_p0[r][K-1] <= col_new[r];
            end
        end
    end

    // Stage 1: per-tap products
    always_ff @(posedge clk) begin
        if (en) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    prod_p1[r][c] <= PW'(win_p0[r][c]) * PW'(coef[r][c]);
                end
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                acc = acc + ACC_W'(prod_p1[r][c]);
            end
        end
    end

    assign scaled = acc >>> OutShift;

    // Stage 2: reduce, scale, saturate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out_p2 <= '0;
        end else if (en && vld_p1) begin
            d_out_p2 <= saturate(scaled);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p0 <= win_ok;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

endmodule
